hazard_ctrl_unit: RTL

Parametrised next-generation hazard unit for the MIPS pipeline. Per-operand forwarding selects over a configurable number of later stages, youngest first. Adds load-use stall and bubble insertion, plus a multi-cycle MUL/DIV busy tracker that stalls dependent issue. Keeps branch-mispredict and jump flush, with flush taking priority over every stall.

---
 rtl/hazard_ctrl_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//   Hazard control for the MIPS pipeline: per-operand forwarding select over
//   FWD_STAGES later stages (youngest wins), load-use stall with EX bubble,
//   MUL/DIV busy tracking that stalls dependent issue, and branch-mispredict /
//   jump flush which overrides every stall.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rs/rt_iss_hz_i           source registers of the ISSUE instruction
//   rs/rt/rd_ex_hz_i         source/destination registers of the EX instruction
//   mem_to_reg_ex_hz_i       EX instruction is a load
//   reg_wr_ex_hz_i           EX instruction writes a register
//   rd_fwd_hz_i              destination per forwarding stage (stage 1 in LSBs)
//   reg_wr_fwd_hz_i          register-write enable per forwarding stage
//   branch_taken_ex_hz_i     EX branch resolved taken
//   brn_pred_ex_hz_i         EX branch was predicted taken
//   jump_iss_hz_i            jump resolved in ISSUE
//   md_start_ex_hz_i         MUL/DIV launch pulse from EX
//   md_use_iss_hz_i          ISSUE instruction depends on the MUL/DIV unit
//   stall_fetch/iss_hz_o     hold PC/fetch and ISSUE registers
//   flush_ex/iss_hz_o        load NO-OP into EX / ISSUE registers
//   fwd_p1/p2_hz_o           operand source: 0 = regfile, k = stage k
//   md_busy_hz_o, md_done_hz_o  MUL/DIV in progress / last busy cycle
//
// Optional feature macro: HZ_PERF_CNT_EN
//   When defined, adds saturating 32-bit stall_cnt_hz_o and flush_cnt_hz_o.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_STAGES = 2,
   parameter int MD_LATENCY = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [REG_ADDR_W-1:0]            rs_iss_hz_i,
   input  logic [REG_ADDR_W-1:0]            rt_iss_hz_i,
   input  logic [REG_ADDR_W-1:0]            rs_ex_hz_i,
   input  logic [REG_ADDR_W-1:0]            rt_ex_hz_i,
   input  logic [REG_ADDR_W-1:0]            rd_ex_hz_i,
   input  logic                             mem_to_reg_ex_hz_i,
   input  logic                             reg_wr_ex_hz_i,
   input  logic [FWD_STAGES*REG_ADDR_W-1:0] rd_fwd_hz_i,
   input  logic [FWD_STAGES-1:0]            reg_wr_fwd_hz_i,
   input  logic                             branch_taken_ex_hz_i,
   input  logic                             brn_pred_ex_hz_i,
   input  logic                             jump_iss_hz_i,
   input  logic                             md_start_ex_hz_i,
   input  logic                             md_use_iss_hz_i,
   output logic                             stall_fetch_hz_o,
   output logic                             stall_iss_hz_o,
   output logic                             flush_ex_hz_o,
   output logic                             flush_iss_hz_o,
   output logic [1:0]                       fwd_p1_hz_o,
   output logic [1:0]                       fwd_p2_hz_o,
   output logic                             md_busy_hz_o,
`ifdef HZ_PERF_CNT_EN
   output logic                             md_done_hz_o,
   output logic [31:0]                      stall_cnt_hz_o,
   output logic [31:0]                      flush_cnt_hz_o
`else
   output logic                             md_done_hz_o
`endif
);

   // active_q rises on the first clock edge after reset release, so that
   // release takes effect on an edge while assertion clears outputs at once.
   logic       active_q;
   logic [7:0] md_cnt_q, md_cnt_d;
   logic [1:0] fwd_p1, fwd_p2;
   logic       mispredict, lu, mds, stall, md_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) active_q <= 1'b0;
      else        active_q <= 1'b1;
   end

   // Scan oldest to youngest so the youngest matching stage is the last write.
   always_comb begin
      fwd_p1 = 2'd0;
      fwd_p2 = 2'd0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (reg_wr_fwd_hz_i[k-1] && (rd_fwd_hz_i[k*REG_ADDR_W-1 -: REG_ADDR_W] != '0)) begin
            if (rd_fwd_hz_i[k*REG_ADDR_W-1 -: REG_ADDR_W] == rs_ex_hz_i) fwd_p1 = 2'(k);
            if (rd_fwd_hz_i[k*REG_ADDR_W-1 -: REG_ADDR_W] == rt_ex_hz_i) fwd_p2 = 2'(k);
         end
      end
   end

   assign mispredict = branch_taken_ex_hz_i & ~brn_pred_ex_hz_i;
   assign lu         = mem_to_reg_ex_hz_i & reg_wr_ex_hz_i & (|rd_ex_hz_i) &
                       ((rd_ex_hz_i == rs_iss_hz_i) | (rd_ex_hz_i == rt_iss_hz_i));
   assign mds        = md_use_iss_hz_i & ((md_cnt_q != 8'd0) | md_start_ex_hz_i);
   assign stall      = (lu | mds) & ~mispredict & ~jump_iss_hz_i;
   assign md_start   = md_start_ex_hz_i & active_q;

   // A start while busy is ignored; the running count is never reloaded.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_cnt_q == 8'd0) begin
         if (md_start) md_cnt_d = 8'(MD_LATENCY);
      end else begin
         md_cnt_d = md_cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) md_cnt_q <= 8'd0;
      else        md_cnt_q <= md_cnt_d;
   end

   assign stall_fetch_hz_o = active_q & stall;
   assign stall_iss_hz_o   = active_q & stall;
   assign flush_ex_hz_o    = active_q & (mispredict | stall);
   assign flush_iss_hz_o   = active_q & (mispredict | jump_iss_hz_i);
   assign fwd_p1_hz_o      = active_q ? fwd_p1 : 2'd0;
   assign fwd_p2_hz_o      = active_q ? fwd_p2 : 2'd0;
   assign md_busy_hz_o     = active_q & (md_cnt_q != 8'd0);
   assign md_done_hz_o     = active_q & (md_cnt_q == 8'd1);

`ifdef HZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   assign stall_cnt_d = sat_inc(stall_cnt_q, stall_iss_hz_o);
   assign flush_cnt_d = sat_inc(flush_cnt_q, flush_iss_hz_o);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_hz_o = stall_cnt_q;
   assign flush_cnt_hz_o = flush_cnt_q;
`endif

endmodule
